ldm_stm_sequencer: RTL and testbench
====================================

// Module: ldm_stm_sequencer
// PURPOSE
//  Multi-register transfer engine for ARM LDM/STM: walks a 16-bit register list and moves each listed
//  register between the register file and data memory, one word per memory handshake.
//  Drives the register file's read port (STM data) and write port (LDM data, base writeback).
//  Sits between the decode/execute control and the data-memory interface.
//  Stalls execute via busy while a transfer runs.
// PARAMETERS
//  WORD_SIZE   32  data/address width in bits; address step per word = WORD_SIZE/8
//  NUM_REGS    16  architectural registers; width of reg_list
//  ADDR_WIDTH  4   register index width, log2(NUM_REGS)
// PORTS
//  clk          in   1           clock
//  reset        in   1           synchronous, active-high reset
//  start        in   1           begin transfer; sampled only in IDLE
//  is_load      in   1           1 = LDM (mem->reg), 0 = STM (reg->mem)
//  up           in   1           1 = increment, 0 = decrement
//  pre          in   1           1 = before (IB/DB), 0 = after (IA/DA)
//  wback        in   1           write final address back to base_reg
//  base_reg     in   ADDR_WIDTH  base register index
//  base_addr    in   WORD_SIZE   base register value
//  reg_list     in   NUM_REGS    bit i set = transfer register i
//  busy         out  1           transfer in progress
//  done         out  1           one-cycle completion pulse
//  rf_rd_reg    out  ADDR_WIDTH  register file read index (STM source)
//  rf_rd_data   in   WORD_SIZE   register file read data (combinational read)
//  rf_wr_en     out  1           register file write strobe
//  rf_wr_reg    out  ADDR_WIDTH  register file write index
//  rf_wr_data   out  WORD_SIZE   register file write data
//  mem_req      out  1           memory request
//  mem_we       out  1           1 = write (STM)
//  mem_addr     out  WORD_SIZE   byte address
//  mem_wdata    out  WORD_SIZE   store data
//  mem_rdata    in   WORD_SIZE   load data; valid when mem_ack = 1
//  mem_ack      in   1           request completes this cycle
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. Pending list and load data are discarded.
//   Reset mid-transfer: mem_req drops on the next cycle. No further rf write occurs and done does not pulse.
//  States: IDLE -> XFER -> DRAIN -> WB -> IDLE.
//  IDLE, start=1:
//   - Latch reg_list, is_load, base_reg, wback.
//   - n = popcount(reg_list). Word step W = WORD_SIZE/8.
//   - Start address: IA = base; IB = base+W; DA = base-W*n+W; DB = base-W*n.
//   - Final address: up ? base+W*n : base-W*n.
//   - All arithmetic is modulo 2^WORD_SIZE (wrap-around, no error).
//  Empty reg_list: no memory access and no rf write. Go straight to IDLE; done=1 the cycle after start.
//  start while busy: ignored. start in the cycle done=1: accepted.
//  XFER:
//   - Current register = lowest-numbered set bit of the remaining list, so the lowest register maps to the lowest address.
//   - mem_req=1, mem_we=!is_load, mem_addr = current address, rf_rd_reg = current register, mem_wdata = rf_rd_data.
//   - Hold all request outputs stable until mem_ack=1. mem_ack while mem_req=0 is ignored.
//   - On ack: clear the bit and add W to the address. The next request is presented the following cycle (back-to-back allowed).
//   - LDM: rf_wr_en=1 for one cycle after each ack, with rf_wr_reg = that register and rf_wr_data = the registered mem_rdata.
//  After the final ack: DRAIN for one cycle (carries the last load write; idle for STM), then WB for one cycle.
//  WB: rf_wr_en=1, rf_wr_reg=base_reg, rf_wr_data=final address, only if wback=1 and NOT (is_load and base_reg in list).
//   For LDM with base in list, the loaded value wins.
//  Timing: done=1 and busy=0 in the cycle after WB. busy=1 from the cycle after start through WB.
//  Never more than one rf write per cycle.
//  r15 in the list is transferred as an ordinary register; PC side effects belong to the caller.
// TESTING
//  1 STM IA, base=0x1000, list=0x000A, wback=1, ack immediate -> mem[0x1000]=r1, mem[0x1004]=r3; r_base<=0x1008; done once.
//  2 LDM DB, base=0x2000, list=0x8001 -> r0<=mem[0x1FF8], r15<=mem[0x1FFC]; wback gives base 0x1FF8.
//  3 LDM IA, base_reg=2, list=0x0006, wback=1 -> r2 holds the loaded word; no base writeback.
//  4 STM with mem_ack delayed 3 cycles per word -> mem_req, mem_addr and mem_wdata are stable during the stall; exactly one write per word.
//  5 list=0x0000 -> no mem_req, no rf_wr_en; done=1 the cycle after start. IA at base=0xFFFFFFFC, 2 regs -> addresses 0xFFFFFFFC, 0x00000000.
//  6 reset asserted mid-XFER -> next cycle mem_req=0, busy=0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ldm_stm_sequencer
//  Purpose  : LDM/STM multi-register transfer engine; walks a register list,
//             one memory word per handshake, with optional base writeback.
//  Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  up,
    input  logic                  pre,
    input  logic                  wback,
    input  logic [ADDR_WIDTH-1:0] base_reg,
    input  logic [WORD_SIZE-1:0]  base_addr,
    input  logic [NUM_REGS-1:0]   reg_list,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_rd_reg,
    input  logic [WORD_SIZE-1:0]  rf_rd_data,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_reg,
    output logic [WORD_SIZE-1:0]  rf_wr_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    input  logic                  mem_ack
);

    localparam int                   CNT_W       = ADDR_WIDTH + 1;
    localparam logic [WORD_SIZE-1:0] c_word_step = WORD_SIZE'(WORD_SIZE / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [NUM_REGS-1:0]   r_list;
    logic                  r_is_load;
    logic                  r_wback;
    logic                  r_base_in_list;
    logic [ADDR_WIDTH-1:0] r_base_reg;
    logic [WORD_SIZE-1:0]  r_addr;
    logic [WORD_SIZE-1:0]  r_final;
    logic                  r_done;
    logic                  r_ld_wr_en;
    logic [ADDR_WIDTH-1:0] r_ld_reg;
    logic [WORD_SIZE-1:0]  r_ld_data;

    logic [CNT_W-1:0]      w_count;
    logic [WORD_SIZE-1:0]  w_span;
    logic [WORD_SIZE-1:0]  w_start_addr;
    logic [WORD_SIZE-1:0]  w_final_addr;
    logic [ADDR_WIDTH-1:0] w_cur;
    logic [NUM_REGS-1:0]   w_list_rest;
    logic                  w_ack;
    logic                  w_wb_en;
    logic                  w_done_next;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_count = w_count + CNT_W'(reg_list[i]);
        end
    end

    assign w_span       = WORD_SIZE'(w_count) * c_word_step;
    assign w_final_addr = up ? (base_addr + w_span) : (base_addr - w_span);
    assign w_start_addr = up ? (pre ? base_addr + c_word_step : base_addr)
                             : (pre ? base_addr - w_span
                                    : base_addr - w_span + c_word_step);

    // Lowest set bit goes first so the lowest register lands at the lowest address
    always_comb begin
        w_cur = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (r_list[i]) begin
                w_cur = ADDR_WIDTH'(i);
            end
        end
    end

    assign w_list_rest = r_list & ~(NUM_REGS'(1) << w_cur);
    assign w_ack       = (r_state == S_XFER) && mem_ack;
    assign w_wb_en     = r_wback && !(r_is_load && r_base_in_list);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = r_done;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        rf_rd_reg    = '0;
        rf_wr_en     = 1'b0;
        rf_wr_reg    = '0;
        rf_wr_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (reg_list == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = S_XFER;
                    end
                end
            end
            S_XFER: begin
                mem_req   = 1'b1;
                mem_we    = !r_is_load;
                mem_addr  = r_addr;
                rf_rd_reg = w_cur;
                mem_wdata = r_is_load ? '0 : rf_rd_data;
                if (mem_ack && (w_list_rest == '0)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_WB;
            end
            S_WB: begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Load write-back and base write-back never overlap: WB follows DRAIN
        if (r_ld_wr_en) begin
            rf_wr_en   = 1'b1;
            rf_wr_reg  = r_ld_reg;
            rf_wr_data = r_ld_data;
        end else if ((r_state == S_WB) && w_wb_en) begin
            rf_wr_en   = 1'b1;
            rf_wr_reg  = r_base_reg;
            rf_wr_data = r_final;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_list         <= '0;
            r_is_load      <= 1'b0;
            r_wback        <= 1'b0;
            r_base_in_list <= 1'b0;
            r_base_reg     <= '0;
            r_addr         <= '0;
            r_final        <= '0;
            r_done         <= 1'b0;
            r_ld_wr_en     <= 1'b0;
            r_ld_reg       <= '0;
            r_ld_data      <= '0;
        end else begin
            r_done     <= w_done_next;
            r_ld_wr_en <= w_ack && r_is_load;
            if (w_ack) begin
                r_ld_reg  <= w_cur;
                r_ld_data <= mem_rdata;
            end
            if ((r_state == S_IDLE) && start) begin
                r_list         <= reg_list;
                r_is_load      <= is_load;
                r_wback        <= wback;
                r_base_reg     <= base_reg;
                r_base_in_list <= reg_list[base_reg];
                r_addr         <= w_start_addr;
                r_final        <= w_final_addr;
            end else if (w_ack) begin
                r_list <= w_list_rest;
                r_addr <= r_addr + c_word_step;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldm_stm_sequencer
//  Purpose  : Scoreboard bench for ldm_stm_sequencer with memory/regfile models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, is_load, up, pre, wback;
    logic [3:0]  base_reg;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic        busy, done;
    logic [3:0]  rf_rd_reg, rf_wr_reg;
    logic [31:0] rf_rd_data, rf_wr_data;
    logic        rf_wr_en, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] rf [16];

    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } mem_exp_t;
    typedef struct { logic [3:0] rg; logic [31:0] data; } rf_exp_t;
    mem_exp_t exp_mem[$];
    rf_exp_t  exp_rf[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ack_delay = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_reg];

    ldm_stm_sequencer #(.WORD_SIZE(32), .NUM_REGS(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up),
        .pre(pre), .wback(wback), .base_reg(base_reg), .base_addr(base_addr),
        .reg_list(reg_list), .busy(busy), .done(done), .rf_rd_reg(rf_rd_reg),
        .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg),
        .rf_wr_data(rf_wr_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory responder and output monitor; everything sampled on the falling edge
    initial begin : bfm
        mem_exp_t    e;
        rf_exp_t     r;
        int          wait_cnt;
        logic        pend;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        wait_cnt = 0;
        pend     = 1'b0;
        mem_ack  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (pend) begin
                    check("hold_addr", mem_addr, h_addr);
                    check("hold_wdata", mem_wdata, h_wdata);
                    check("hold_we", {31'b0, mem_we}, {31'b0, h_we});
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = pat(mem_addr);
                    pend      = 1'b0;
                    wait_cnt  = 0;
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                        if (e.we) check("mem_wdata", mem_wdata, e.data);
                    end
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = '0;
                    wait_cnt++;
                    pend    = 1'b1;
                    h_addr  = mem_addr;
                    h_wdata = mem_wdata;
                    h_we    = mem_we;
                end
            end else begin
                mem_ack  = 1'b0;
                pend     = 1'b0;
                wait_cnt = 0;
            end
            if (rf_wr_en) begin
                if (exp_rf.size() == 0) begin
                    check("rf_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_rf.pop_front();
                    check("rf_wr_reg", {28'b0, rf_wr_reg}, {28'b0, r.rg});
                    check("rf_wr_data", rf_wr_data, r.data);
                end
                rf[rf_wr_reg] = rf_wr_data;
            end
            if (done) done_cnt++;
        end
    end

    task automatic drive_start(input logic ld, input logic u, input logic p, input logic wb,
                               input logic [3:0] br, input logic [31:0] ba,
                               input logic [15:0] lst, output int lat);
        int          n, k;
        logic [31:0] sa, fa, a;
        n  = $countones(lst);
        sa = u ? (p ? ba + 32'd4 : ba) : (p ? ba - 32'(4 * n) : ba - 32'(4 * n) + 32'd4);
        fa = u ? ba + 32'(4 * n) : ba - 32'(4 * n);
        k  = 0;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                a = sa + 32'(4 * k);
                exp_mem.push_back('{addr: a, we: !ld, data: rf[i]});
                if (ld) exp_rf.push_back('{rg: 4'(i), data: pat(a)});
                k++;
            end
        end
        if (n != 0 && wb && !(ld && lst[br])) exp_rf.push_back('{rg: br, data: fa});
        lat = (n == 0) ? 1 : n * (ack_delay + 1) + 3;
        start = 1'b1; is_load = ld; up = u; pre = p; wback = wb;
        base_reg = br; base_addr = ba; reg_list = lst;
        tick();
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic ld, input logic u, input logic p, input logic wb,
                            input logic [3:0] br, input logic [31:0] ba, input logic [15:0] lst);
        int lat, c, d0;
        d0 = done_cnt;
        drive_start(ld, u, p, wb, br, ba, lst, lat);
        c = 1;
        check("busy_first", {31'b0, busy}, {31'b0, (lat > 1)});
        while (!done && c < 400) begin
            tick();
            c++;
        end
        check("done_latency", c, lat);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        tick();
        check("done_once", done_cnt, d0 + 1);
        check("mem_queue_drained", exp_mem.size(), 32'd0);
        check("rf_queue_drained", exp_rf.size(), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat, d0;
        for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + 32'(i * 32'h0101_0011);
        reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
        base_reg = '0; base_addr = '0; reg_list = '0;
        repeat (3) tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_rf_wr_en", {31'b0, rf_wr_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rf_wr_data", rf_wr_data, 32'd0);
        reset = 1'b0;
        tick();

        run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_1000, 16'h000A);  // STM IA
        run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_2000, 16'h8001);  // LDM DB
        run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0000_3000, 16'h0006);  // LDM IA, base in list
        ack_delay = 3;
        run_xfer(1'b0, 1'b1, 1'b1, 1'b0, 4'd4,  32'h0000_5000, 16'h0124);  // STM IB, stalled
        ack_delay = 0;
        run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd7,  32'h0000_7000, 16'h0000);  // empty list
        run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  32'hFFFF_FFFC, 16'h0003);  // wrap-around
        run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  32'h0000_6000, 16'h0111);  // STM DA, base in list
        ack_delay = 1;
        run_xfer(1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  32'h0000_8000, 16'hFFFF);  // LDM IB, full list

        // Abort a stalled LDM mid-transfer
        ack_delay = 2;
        drive_start(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_4000, 16'h00F0, lat);
        repeat (4) tick();
        reset = 1'b1;
        exp_mem.delete();
        exp_rf.delete();
        d0 = done_cnt;
        tick();
        check("abort_mem_req", {31'b0, mem_req}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_rf_wr_en", {31'b0, rf_wr_en}, 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        check("abort_no_done", done_cnt, d0);
        ack_delay = 0;
        run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_4000, 16'h00F0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
